// File: rtl/fpi2c_target.sv
// I2C target emulating a byte-wide register file with an auto-increment pointer.
// Build option FPI2CTGT_FILTER_EN adds a FILT-sample stability filter on SCL/SDA.
module fpi2c_target #(
    parameter logic [6:0]  ADDR = 7'h20,
    parameter int unsigned NREG = 32,
    parameter int unsigned FILT = 3,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          scli,
    input  logic          sdai,
    output logic          sdao,
    input  logic          lclwrite,
    input  logic [AW-1:0] lcladdr,
    input  logic [7:0]    lclwdata,
    output logic [7:0]    lclrdata,
    output logic          wrstrobe,
    output logic [AW-1:0] wraddr,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_AACK, S_RXBYTE, S_DACK, S_TXBYTE, S_TACK, S_WAITSTOP
    } state_t;

    if (NREG < 2 || NREG > 256 || FILT < 1) begin : g_bad_params
        $error("fpi2c_target: NREG must be 2..256 and FILT at least 1");
    end

    state_t        r_state, w_state_nx;
    logic [1:0]    r_scl_sync, r_sda_sync;
    logic          w_scl, w_sda, r_scl_d, r_sda_d;
    logic          r_sdao, r_busy, r_first, r_nack, r_wrstrobe;
    logic [3:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic [AW-1:0] r_ptr, r_wraddr;
    logic [7:0]    r_regs [NREG];

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scli};
            r_sda_sync <= {r_sda_sync[0], sdai};
        end
    end

`ifdef FPI2CTGT_FILTER_EN
    localparam int unsigned CW = $clog2(FILT + 1);
    logic [CW-1:0] r_scl_cnt, r_sda_cnt;
    logic          r_scl_flt, r_sda_flt;

    // Output follows input only after FILT consecutive samples disagreeing with it.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_scl_cnt <= '0;
            r_sda_cnt <= '0;
            r_scl_flt <= 1'b1;
            r_sda_flt <= 1'b1;
        end else begin
            if (r_scl_sync[1] == r_scl_flt) r_scl_cnt <= '0;
            else if (r_scl_cnt == CW'(FILT - 1)) begin
                r_scl_flt <= r_scl_sync[1];
                r_scl_cnt <= '0;
            end else r_scl_cnt <= r_scl_cnt + CW'(1);
            if (r_sda_sync[1] == r_sda_flt) r_sda_cnt <= '0;
            else if (r_sda_cnt == CW'(FILT - 1)) begin
                r_sda_flt <= r_sda_sync[1];
                r_sda_cnt <= '0;
            end else r_sda_cnt <= r_sda_cnt + CW'(1);
        end
    end
    assign w_scl = r_scl_flt;
    assign w_sda = r_sda_flt;
`else
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
`endif

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_addr_hit;
    logic [7:0] w_rxbyte;
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_rxbyte   = {r_shift[6:0], w_sda};
    assign w_addr_hit = (r_shift[7:1] == ADDR);

    always_ff @(posedge CLOCK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (w_stop) w_state_nx = S_IDLE;
        else if (w_start) w_state_nx = S_ADDR;
        else if (w_scl_fall) begin
            case (r_state)
                S_ADDR:   if (r_bitcnt == 4'd8) w_state_nx = w_addr_hit ? S_AACK : S_WAITSTOP;
                S_AACK:   w_state_nx = r_shift[0] ? S_TXBYTE : S_RXBYTE;
                S_RXBYTE: if (r_bitcnt == 4'd8) w_state_nx = S_DACK;
                S_DACK:   w_state_nx = S_RXBYTE;
                S_TXBYTE: if (r_bitcnt == 4'd8) w_state_nx = S_TACK;
                S_TACK:   w_state_nx = r_nack ? S_WAITSTOP : S_TXBYTE;
                default:  w_state_nx = r_state;
            endcase
        end
    end

    // Local write precedes bus write so a same-cycle bus write to the same register wins.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_sdao     <= 1'b1;
            r_busy     <= 1'b0;
            r_first    <= 1'b0;
            r_nack     <= 1'b0;
            r_wrstrobe <= 1'b0;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_ptr      <= '0;
            r_wraddr   <= '0;
            for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            r_wrstrobe <= 1'b0;
            if (lclwrite) r_regs[lcladdr] <= lclwdata;
            if (w_stop) begin
                r_busy <= 1'b0;
                r_sdao <= 1'b1;
            end else if (w_start) begin
                r_busy   <= 1'b1;
                r_bitcnt <= '0;
            end else if (w_scl_rise) begin
                case (r_state)
                    S_ADDR: begin
                        r_shift  <= w_rxbyte;
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end
                    S_RXBYTE: begin
                        r_shift  <= w_rxbyte;
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            r_first <= 1'b0;
                            if (r_first) r_ptr <= w_rxbyte[AW-1:0];
                            else begin
                                r_regs[r_ptr] <= w_rxbyte;
                                r_wrstrobe    <= 1'b1;
                                r_wraddr      <= r_ptr;
                                r_ptr         <= r_ptr + AW'(1);
                            end
                        end
                    end
                    S_TXBYTE: r_bitcnt <= r_bitcnt + 4'd1;
                    S_TACK: begin
                        r_nack <= w_sda;
                        if (!w_sda) r_ptr <= r_ptr + AW'(1);
                    end
                    default: ;
                endcase
            end else if (w_scl_fall) begin
                case (r_state)
                    S_ADDR: if (r_bitcnt == 4'd8 && w_addr_hit) r_sdao <= 1'b0;
                    S_AACK: begin
                        r_bitcnt <= '0;
                        if (r_shift[0]) begin
                            r_sdao  <= r_regs[r_ptr][7];
                            r_shift <= {r_regs[r_ptr][6:0], 1'b0};
                        end else begin
                            r_sdao  <= 1'b1;
                            r_first <= 1'b1;
                        end
                    end
                    S_RXBYTE: if (r_bitcnt == 4'd8) r_sdao <= 1'b0;
                    S_DACK: begin
                        r_sdao   <= 1'b1;
                        r_bitcnt <= '0;
                    end
                    S_TXBYTE: begin
                        if (r_bitcnt == 4'd8) r_sdao <= 1'b1;
                        else begin
                            r_sdao  <= r_shift[7];
                            r_shift <= {r_shift[6:0], 1'b0};
                        end
                    end
                    S_TACK: if (!r_nack) begin
                        r_bitcnt <= '0;
                        r_sdao   <= r_regs[r_ptr][7];
                        r_shift  <= {r_regs[r_ptr][6:0], 1'b0};
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sdao     = r_sdao;
    assign busy     = r_busy;
    assign wrstrobe = r_wrstrobe;
    assign wraddr   = r_wraddr;
    assign lclrdata = r_regs[lcladdr];

endmodule

// File: tb/tb_fpi2c_target.sv
// Bench for fpi2c_target: bit-banged I2C master, register-file reference model,
// and a scoreboard monitor for write strobes, ACK bits and read bytes.
module tb_fpi2c_target;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int Q    = 8;

    logic          clk, rst;
    logic          m_scl, m_sda, sdai, sdao;
    logic          lclwrite, wrstrobe, busy;
    logic [AW-1:0] lcladdr, wraddr;
    logic [7:0]    lclwdata, lclrdata;

    assign sdai = m_sda & sdao;

    fpi2c_target #(.ADDR(7'h20), .NREG(NREG), .FILT(3)) dut (
        .CLOCK(clk), .RESET(rst), .scli(m_scl), .sdai(sdai), .sdao(sdao),
        .lclwrite(lclwrite), .lcladdr(lcladdr), .lclwdata(lclwdata),
        .lclrdata(lclrdata), .wrstrobe(wrstrobe), .wraddr(wraddr), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int rel_viol = 0;
    bit watch_rel = 1'b0;

    logic [31:0] exp_wr[$];
    logic [31:0] exp_ack[$], obs_ack[$];
    logic [31:0] exp_rd[$], obs_rd[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  mdl [NREG];
    int          mdl_ptr = 0;
    int          gl_byte = -1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0 && wrstrobe === 1'b1) begin
            if (exp_wr.size() == 0) chk("wrstrobe_unexpected", 32'(wrstrobe), 32'd0);
            else chk("wraddr", 32'(wraddr), exp_wr.pop_front());
        end
        while (obs_ack.size() > 0 && exp_ack.size() > 0) chk("ack", obs_ack.pop_front(), exp_ack.pop_front());
        while (obs_rd.size() > 0 && exp_rd.size() > 0) chk("rdbyte", obs_rd.pop_front(), exp_rd.pop_front());
        if (watch_rel && sdao !== 1'b1) rel_viol++;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; cyc(Q);
        m_scl = 1'b1; cyc(Q);
        m_sda = 1'b0; cyc(Q);
        m_scl = 1'b0; cyc(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; cyc(Q);
        m_scl = 1'b1; cyc(Q);
        m_sda = 1'b1; cyc(Q);
    endtask

    task automatic put_bit(input logic b, input bit glitch);
        m_sda = b;
        cyc(Q / 2);
        if (glitch) begin
            m_scl = 1'b1; cyc(2);
            m_scl = 1'b0;
        end
        cyc(Q / 2);
        m_scl = 1'b1; cyc(Q);
        m_scl = 1'b0; cyc(Q);
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1; cyc(Q);
        m_scl = 1'b1; cyc(Q / 2);
        b = sdai;     cyc(Q / 2);
        m_scl = 1'b0; cyc(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ea, input int gbit);
        logic a;
        exp_ack.push_back(32'(ea));
        for (int i = 7; i >= 0; i--) put_bit(b[i], i == gbit);
        get_bit(a);
        obs_ack.push_back(32'(a));
    endtask

    task automatic recv_bytes(input int n);
        logic [7:0] v;
        logic       bt;
        for (int k = 0; k < n; k++) begin
            exp_rd.push_back(32'(mdl[mdl_ptr]));
            for (int i = 7; i >= 0; i--) begin
                get_bit(bt);
                v[i] = bt;
            end
            obs_rd.push_back(32'(v));
            put_bit(k == n - 1, 1'b0);
            if (k != n - 1) mdl_ptr = (mdl_ptr + 1) % NREG;
        end
    endtask

    task automatic wr_tr(input logic [7:0] ptr);
        bus_start();
        send_byte(8'h40, 1'b0, -1);
        mdl_ptr = int'(ptr) % NREG;
        send_byte(ptr, 1'b0, -1);
        for (int k = 0; k < tx_q.size(); k++) begin
            exp_wr.push_back(32'(mdl_ptr));
            mdl[mdl_ptr] = tx_q[k];
            mdl_ptr = (mdl_ptr + 1) % NREG;
            send_byte(tx_q[k], 1'b0, (k == gl_byte) ? 4 : -1);
        end
        bus_stop();
    endtask

    task automatic rd_tr(input logic [7:0] ptr, input int n);
        bus_start();
        send_byte(8'h40, 1'b0, -1);
        mdl_ptr = int'(ptr) % NREG;
        send_byte(ptr, 1'b0, -1);
        bus_start();
        send_byte(8'h41, 1'b0, -1);
        recv_bytes(n);
        bus_stop();
    endtask

    task automatic rd_cur(input int n);
        bus_start();
        send_byte(8'h41, 1'b0, -1);
        recv_bytes(n);
        bus_stop();
    endtask

    task automatic lcl_wr(input int a, input logic [7:0] d);
        lclwrite = 1'b1; lcladdr = AW'(a); lclwdata = d;
        cyc(1);
        lclwrite = 1'b0;
        mdl[a] = d;
    endtask

    task automatic check_regs();
        for (int a = 0; a < NREG; a++) begin
            lcladdr = AW'(a);
            #1;
            chk($sformatf("reg%0d", a), 32'(lclrdata), 32'(mdl[a]));
        end
        cyc(1);
    endtask

    initial begin
        logic [7:0] addr_byte;
        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
        lclwrite = 1'b0; lcladdr = '0; lclwdata = '0;
        for (int i = 0; i < NREG; i++) mdl[i] = 8'h00;
        cyc(4);
        chk("rst_sdao", 32'(sdao), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wrstrobe", 32'(wrstrobe), 32'd0);
        chk("rst_wraddr", 32'(wraddr), 32'd0);
        rst = 1'b0;
        cyc(4);
        check_regs();

        // write A5, 3C starting at register 5, then read current pointer (7)
        tx_q = '{8'hA5, 8'h3C};
        wr_tr(8'h05);
        check_regs();
        rd_cur(1);

        // preload, read across the wrap, then confirm pointer sits at 0
        lcl_wr(31, 8'h11);
        lcl_wr(0, 8'h22);
        rd_tr(8'h1F, 2);
        rd_cur(1);

        // foreign address: never drives SDA, stays busy until STOP
        bus_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        watch_rel = 1'b1;
        send_byte(8'h42, 1'b1, -1);
        send_byte(8'h55, 1'b1, -1);
        send_byte(8'hAA, 1'b1, -1);
        watch_rel = 1'b0;
        chk("busy_foreign", 32'(busy), 32'd1);
        bus_stop();
        cyc(4);
        chk("busy_after_stop", 32'(busy), 32'd0);
        chk("release_viol", 32'(rel_viol), 32'd0);

        // partial byte aborted by STOP
        lcl_wr(3, 8'h5A);
        bus_start();
        send_byte(8'h40, 1'b0, -1);
        mdl_ptr = 3;
        send_byte(8'h03, 1'b0, -1);
        put_bit(1'b0, 1'b0); put_bit(1'b1, 1'b0);
        put_bit(1'b1, 1'b0); put_bit(1'b1, 1'b0);
        bus_stop();
        cyc(4);
        chk("partial_sdao", 32'(sdao), 32'd1);
        chk("partial_busy", 32'(busy), 32'd0);
        check_regs();

        // reset while the target holds the address ACK low
        bus_start();
        addr_byte = 8'h40;
        for (int i = 7; i >= 0; i--) put_bit(addr_byte[i], 1'b0);
        chk("ack_driven", 32'(sdao), 32'd0);
        rst = 1'b1;
        cyc(1);
        chk("reset_release", 32'(sdao), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < NREG; i++) mdl[i] = 8'h00;
        mdl_ptr = 0;
        check_regs();
        bus_stop();

        // randomized traffic
        for (int t = 0; t < 6; t++) begin
            int n;
            lcl_wr($urandom_range(0, NREG - 1), 8'($urandom));
            lcl_wr($urandom_range(0, NREG - 1), 8'($urandom));
            n = $urandom_range(1, 4);
            tx_q.delete();
            for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
            wr_tr(8'($urandom));
            rd_tr(8'($urandom), $urandom_range(1, 3));
            check_regs();
        end

`ifdef FPI2CTGT_FILTER_EN
        // short SCL glitch mid-byte must be rejected by the filter
        tx_q = '{8'h96, 8'hC3};
        gl_byte = 1;
        wr_tr(8'h0A);
        gl_byte = -1;
        check_regs();
`endif

        cyc(20);
        chk("exp_wr_left", 32'(exp_wr.size()), 32'd0);
        chk("exp_ack_left", 32'(exp_ack.size()), 32'd0);
        chk("exp_rd_left", 32'(exp_rd.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
